// File: rtl/ipic_burst_arbiter.sv
// Round-robin arbiter that shares one IPIC burst master between NUM_REQ
// requesters. It latches the winner's command, sequences the master
// start/ack/done handshake, returns per-requester ack/done pulses and aborts
// hung transactions with a watchdog.
module ipic_burst_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int ADDR_WIDTH     = 32,
  parameter int C_LENGTH_WIDTH = 14,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [NUM_REQ-1:0]                 req_start,
  input  logic [3*NUM_REQ-1:0]               req_type,
  input  logic [ADDR_WIDTH*NUM_REQ-1:0]      req_read_addr,
  input  logic [ADDR_WIDTH*NUM_REQ-1:0]      req_write_addr,
  input  logic [C_LENGTH_WIDTH*NUM_REQ-1:0]  req_write_length,
  output logic [NUM_REQ-1:0]                 req_ack,
  output logic [NUM_REQ-1:0]                 req_done,
  output logic                               req_err,
  output logic                               ipic_start,
  output logic [2:0]                         ipic_type,
  output logic [ADDR_WIDTH-1:0]              read_addr,
  output logic [ADDR_WIDTH-1:0]              write_addr,
  output logic [C_LENGTH_WIDTH-1:0]          write_length,
  input  logic                               ipic_ack,
  input  logic                               ipic_done_wire,
  output logic [2:0]                         grant_id,
  output logic                               busy,
  output logic [15:0]                        timeout_count
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int WD_W  = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  // The watchdog value is the number of cycles already spent in START/RUN;
  // aborting when it reaches TIMEOUT_CYCLES-1 makes the abort pulse appear
  // exactly TIMEOUT_CYCLES cycles after ipic_start rose.
  localparam logic [WD_W-1:0]  WD_LAST  = WD_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_RUN, S_RELEASE} state_t;

  state_t                      state_q, state_d;
  logic [PTR_W-1:0]            rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0]            grant_id_q, grant_id_d;
  logic [WD_W-1:0]             wd_q, wd_d;
  logic [15:0]                 timeout_count_q, timeout_count_d;
  logic                        ipic_start_q, ipic_start_d;
  logic                        busy_q, busy_d;
  logic                        req_err_q, req_err_d;
  logic [NUM_REQ-1:0]          req_ack_q, req_ack_d;
  logic [NUM_REQ-1:0]          req_done_q, req_done_d;
  logic [2:0]                  ipic_type_q, ipic_type_d;
  logic [ADDR_WIDTH-1:0]       read_addr_q, read_addr_d;
  logic [ADDR_WIDTH-1:0]       write_addr_q, write_addr_d;
  logic [C_LENGTH_WIDTH-1:0]   write_length_q, write_length_d;

  logic                        win_vld;
  logic [PTR_W-1:0]            win_idx;
  logic                        wd_hit;

  // Round-robin search: first set request at or above rr_ptr, wrapping.
  always_comb begin
    int idx;
    idx     = 0;
    win_vld = 1'b0;
    win_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = int'(rr_ptr_q) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!win_vld && req_start[idx]) begin
        win_vld = 1'b1;
        win_idx = PTR_W'(idx);
      end
    end
  end

  assign wd_hit = (TIMEOUT_CYCLES != 0) && (wd_q == WD_LAST);

  // Next-state logic for the handshake FSM, watchdog and latched command.
  always_comb begin
    int wi;
    wi              = int'(win_idx);
    state_d         = state_q;
    rr_ptr_d        = rr_ptr_q;
    grant_id_d      = grant_id_q;
    wd_d            = wd_q;
    timeout_count_d = timeout_count_q;
    ipic_start_d    = ipic_start_q;
    req_err_d       = 1'b0;
    req_ack_d       = '0;
    req_done_d      = '0;
    ipic_type_d     = ipic_type_q;
    read_addr_d     = read_addr_q;
    write_addr_d    = write_addr_q;
    write_length_d  = write_length_q;
    case (state_q)
      S_IDLE: begin
        if (win_vld) begin
          grant_id_d     = win_idx;
          ipic_type_d    = req_type[3*wi +: 3];
          read_addr_d    = req_read_addr[ADDR_WIDTH*wi +: ADDR_WIDTH];
          write_addr_d   = req_write_addr[ADDR_WIDTH*wi +: ADDR_WIDTH];
          write_length_d = req_write_length[C_LENGTH_WIDTH*wi +: C_LENGTH_WIDTH];
          ipic_start_d   = 1'b1;
          wd_d           = '0;
          state_d        = S_START;
        end
      end
      S_START: begin
        if (ipic_ack) begin
          req_ack_d[grant_id_q] = 1'b1;
          ipic_start_d          = 1'b0;
          wd_d                  = wd_q + 1'b1;
          state_d               = S_RUN;
          if (ipic_done_wire) begin
            req_done_d[grant_id_q] = 1'b1;
            state_d                = S_RELEASE;
          end
        end else if (wd_hit) begin
          ipic_start_d           = 1'b0;
          req_done_d[grant_id_q] = 1'b1;
          req_err_d              = 1'b1;
          state_d                = S_RELEASE;
          if (timeout_count_q != 16'hFFFF) timeout_count_d = timeout_count_q + 16'd1;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      S_RUN: begin
        ipic_start_d = 1'b0;
        if (ipic_done_wire) begin
          req_done_d[grant_id_q] = 1'b1;
          state_d                = S_RELEASE;
        end else if (wd_hit) begin
          req_done_d[grant_id_q] = 1'b1;
          req_err_d              = 1'b1;
          state_d                = S_RELEASE;
          if (timeout_count_q != 16'hFFFF) timeout_count_d = timeout_count_q + 16'd1;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      S_RELEASE: begin
        rr_ptr_d = (grant_id_q == PTR_LAST) ? '0 : grant_id_q + 1'b1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // State and output registers; reset clears everything asynchronously.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= S_IDLE;
      rr_ptr_q        <= '0;
      grant_id_q      <= '0;
      wd_q            <= '0;
      timeout_count_q <= '0;
      ipic_start_q    <= 1'b0;
      busy_q          <= 1'b0;
      req_err_q       <= 1'b0;
      req_ack_q       <= '0;
      req_done_q      <= '0;
      ipic_type_q     <= '0;
      read_addr_q     <= '0;
      write_addr_q    <= '0;
      write_length_q  <= '0;
    end else begin
      state_q         <= state_d;
      rr_ptr_q        <= rr_ptr_d;
      grant_id_q      <= grant_id_d;
      wd_q            <= wd_d;
      timeout_count_q <= timeout_count_d;
      ipic_start_q    <= ipic_start_d;
      busy_q          <= busy_d;
      req_err_q       <= req_err_d;
      req_ack_q       <= req_ack_d;
      req_done_q      <= req_done_d;
      ipic_type_q     <= ipic_type_d;
      read_addr_q     <= read_addr_d;
      write_addr_q    <= write_addr_d;
      write_length_q  <= write_length_d;
    end
  end

  assign req_ack       = req_ack_q;
  assign req_done      = req_done_q;
  assign req_err       = req_err_q;
  assign ipic_start    = ipic_start_q;
  assign ipic_type     = ipic_type_q;
  assign read_addr     = read_addr_q;
  assign write_addr    = write_addr_q;
  assign write_length  = write_length_q;
  assign grant_id      = 3'(grant_id_q);
  assign busy          = busy_q;
  assign timeout_count = timeout_count_q;

endmodule

// File: tb/tb_ipic_burst_arbiter.sv
// Directed scoreboard bench for ipic_burst_arbiter (4 requesters, 20-cycle watchdog).
module tb_ipic_burst_arbiter;

  localparam int NR = 4;
  localparam int AW = 32;
  localparam int LW = 14;
  localparam int TO = 20;

  logic              clk;
  logic              reset;
  logic [NR-1:0]     req_start;
  logic [3*NR-1:0]   req_type;
  logic [AW*NR-1:0]  req_read_addr;
  logic [AW*NR-1:0]  req_write_addr;
  logic [LW*NR-1:0]  req_write_length;
  logic [NR-1:0]     req_ack;
  logic [NR-1:0]     req_done;
  logic              req_err;
  logic              ipic_start;
  logic [2:0]        ipic_type;
  logic [AW-1:0]     read_addr;
  logic [AW-1:0]     write_addr;
  logic [LW-1:0]     write_length;
  logic              ipic_ack;
  logic              ipic_done_wire;
  logic [2:0]        grant_id;
  logic              busy;
  logic [15:0]       timeout_count;

  ipic_burst_arbiter #(
    .NUM_REQ(NR), .ADDR_WIDTH(AW), .C_LENGTH_WIDTH(LW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .reset(reset), .req_start(req_start), .req_type(req_type),
    .req_read_addr(req_read_addr), .req_write_addr(req_write_addr),
    .req_write_length(req_write_length), .req_ack(req_ack), .req_done(req_done),
    .req_err(req_err), .ipic_start(ipic_start), .ipic_type(ipic_type),
    .read_addr(read_addr), .write_addr(write_addr), .write_length(write_length),
    .ipic_ack(ipic_ack), .ipic_done_wire(ipic_done_wire), .grant_id(grant_id),
    .busy(busy), .timeout_count(timeout_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]    id;
    logic [2:0]    typ;
    logic [AW-1:0] ra;
    logic [AW-1:0] wa;
    logic [LW-1:0] len;
  } exp_t;

  exp_t          sb[$];
  logic [2:0]    t_a[NR];
  logic [AW-1:0] ra_a[NR];
  logic [AW-1:0] wa_a[NR];
  logic [LW-1:0] len_a[NR];
  int            checks = 0;
  int            errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_fields();
    for (int i = 0; i < NR; i++) begin
      req_type[3*i +: 3]          = t_a[i];
      req_read_addr[AW*i +: AW]   = ra_a[i];
      req_write_addr[AW*i +: AW]  = wa_a[i];
      req_write_length[LW*i +: LW] = len_a[i];
    end
  endtask

  task automatic push_exp(input int id);
    exp_t e;
    e.id = 3'(id); e.typ = t_a[id]; e.ra = ra_a[id]; e.wa = wa_a[id]; e.len = len_a[id];
    sb.push_back(e);
  endtask

  task automatic pop_exp(output exp_t e, output bit ok);
    ok = (sb.size() != 0);
    chk("sb_nonempty", 64'(ok), 64'd1);
    if (ok) e = sb.pop_front();
    else begin e.id = 0; e.typ = 0; e.ra = 0; e.wa = 0; e.len = 0; end
  endtask

  task automatic wait_start(output bit seen);
    int n;
    n = 0;
    while (ipic_start !== 1'b1 && n < 40) begin tick(); n++; end
    seen = (ipic_start === 1'b1);
    chk("start_seen", 64'(seen), 64'd1);
  endtask

  // One full transaction against the expected grant at the head of the scoreboard.
  task automatic serve(input int ack_wait, input int done_wait, input bit same,
                       input logic [NR-1:0] drop, input bit scramble);
    exp_t e; bit ok; bit seen; logic [NR-1:0] oh;
    wait_start(seen);
    if (!seen) return;
    pop_exp(e, ok);
    oh = NR'(1) << e.id;
    chk("grant_id", 64'(grant_id), 64'(e.id));
    chk("ipic_type", 64'(ipic_type), 64'(e.typ));
    chk("read_addr", 64'(read_addr), 64'(e.ra));
    chk("write_addr", 64'(write_addr), 64'(e.wa));
    chk("write_length", 64'(write_length), 64'(e.len));
    chk("busy_granted", 64'(busy), 64'd1);
    if (scramble) begin
      req_write_addr = ~req_write_addr;
      req_write_length = ~req_write_length;
    end
    repeat (ack_wait) tick();
    chk("start_held", 64'(ipic_start), 64'd1);
    ipic_ack = 1'b1; ipic_done_wire = same;
    tick();
    ipic_ack = 1'b0; ipic_done_wire = 1'b0;
    req_start = req_start & ~drop;
    chk("ack_pulse", 64'(req_ack), 64'(oh));
    chk("done_with_ack", 64'(req_done), same ? 64'(oh) : 64'd0);
    chk("err_ack", 64'(req_err), 64'd0);
    tick();
    chk("ack_single", 64'(req_ack), 64'd0);
    chk("start_dropped", 64'(ipic_start), 64'd0);
    chk("done_single_a", 64'(req_done), 64'd0);
    if (!same) begin
      repeat (done_wait - 1) tick();
      ipic_done_wire = 1'b1;
      tick();
      ipic_done_wire = 1'b0;
      chk("done_pulse", 64'(req_done), 64'(oh));
      chk("err_done", 64'(req_err), 64'd0);
      chk("latched_wa", 64'(write_addr), 64'(e.wa));
      chk("latched_len", 64'(write_length), 64'(e.len));
      tick();
      chk("done_single_b", 64'(req_done), 64'd0);
    end
    if (scramble) apply_fields();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout observed=hang expected=finish");
    $fatal(1, "simulation time limit");
  end

  initial begin
    exp_t e; bit ok; bit seen; int n;
    reset = 1'b1; req_start = '0; ipic_ack = 1'b0; ipic_done_wire = 1'b0;
    for (int i = 0; i < NR; i++) begin
      t_a[i]   = 3'(i);
      ra_a[i]  = 32'hA000_0000 + 32'(i) * 32'h100;
      wa_a[i]  = 32'hB000_0000 + 32'(i) * 32'h10;
      len_a[i] = 14'(i * 8 + 4);
    end
    apply_fields();
    repeat (3) tick();
    chk("rst_start", 64'(ipic_start), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_outs", {req_ack, req_done, req_err, grant_id, ipic_type}, 64'd0);
    chk("rst_addr", {read_addr, write_addr}, 64'd0);
    chk("rst_len_tc", {write_length, timeout_count}, 64'd0);
    reset = 1'b0;
    tick();

    // All four requesting continuously: 0,1,2,3,0 from a reset pointer.
    for (int k = 0; k < 5; k++) push_exp(k % NR);
    req_start = 4'b1111;
    for (int k = 0; k < 4; k++) serve(1, 1, 1'b0, 4'b0000, 1'b0);
    serve(1, 1, 1'b0, 4'b1111, 1'b0);
    tick();

    // Single write burst from requester 2; later field changes are ignored.
    t_a[2] = 3'd1; wa_a[2] = 32'h0000_1020; len_a[2] = 14'd16;
    apply_fields();
    push_exp(2);
    req_start = 4'b0100;
    tick();
    chk("grant_latency", 64'(ipic_start), 64'd1);
    serve(3, 5, 1'b0, 4'b0100, 1'b1);
    tick();

    // Pointer at 3: requests 0 and 1 wrap to 0 first.
    push_exp(0); push_exp(1);
    req_start = 4'b0011;
    serve(1, 2, 1'b0, 4'b0001, 1'b0);
    serve(1, 2, 1'b0, 4'b0010, 1'b0);
    tick();

    // Ack and done in the same cycle; requester 3 is granted two cycles later.
    push_exp(2); push_exp(3);
    req_start = 4'b1100;
    serve(2, 0, 1'b1, 4'b0100, 1'b0);
    tick();
    chk("regrant_2cyc", 64'(ipic_start), 64'd1);
    serve(1, 1, 1'b0, 4'b1000, 1'b0);
    tick();

    // Watchdog abort with no ack, then a late done is ignored.
    push_exp(1);
    req_start = 4'b0010;
    wait_start(seen);
    pop_exp(e, ok);
    chk("to_grant", 64'(grant_id), 64'd1);
    req_start = '0;
    n = 0;
    while (req_done === 4'b0000 && n < 40) begin tick(); n++; end
    chk("to_latency", 64'(n), 64'(TO));
    chk("to_done", 64'(req_done), 64'b0010);
    chk("to_err", 64'(req_err), 64'd1);
    chk("to_start_low", 64'(ipic_start), 64'd0);
    chk("to_count", 64'(timeout_count), 64'd1);
    chk("to_no_ack", 64'(req_ack), 64'd0);
    tick();
    chk("to_err_single", 64'(req_err), 64'd0);
    ipic_done_wire = 1'b1; ipic_ack = 1'b1;
    tick();
    ipic_done_wire = 1'b0; ipic_ack = 1'b0;
    chk("late_done_ignored", 64'(req_done), 64'd0);
    chk("late_ack_ignored", 64'(req_ack), 64'd0);
    chk("late_idle", 64'(busy), 64'd0);
    tick();

    // Asynchronous reset while in RUN.
    push_exp(3);
    req_start = 4'b1000;
    wait_start(seen);
    pop_exp(e, ok);
    chk("rr_grant3", 64'(grant_id), 64'd3);
    ipic_ack = 1'b1;
    tick();
    ipic_ack = 1'b0; req_start = '0;
    chk("rr_ack3", 64'(req_ack), 64'b1000);
    tick();
    chk("run_busy", 64'(busy), 64'd1);
    #2 reset = 1'b1;
    #1;
    chk("arst_start", 64'(ipic_start), 64'd0);
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_pulses", {req_ack, req_done, req_err}, 64'd0);
    chk("arst_gid_wa", {grant_id, write_addr}, 64'd0);
    chk("arst_tc", 64'(timeout_count), 64'd0);
    tick(); tick();
    reset = 1'b0;
    tick();
    push_exp(1);
    req_start = 4'b1010;
    serve(1, 1, 1'b0, 4'b1010, 1'b0);
    tick();
    chk("sb_empty", 64'(sb.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
